fp_normalizer: RTL

FP_NORMALIZER -- requirements
Module: fp_normalizer

---
 rtl/fp_pkg.sv | 12 +
 rtl/fp_pack.sv | 17 +
 rtl/fp_normalizer.sv | 99 +++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared types and defaults for the fp_normalizer slice.
package fp_pkg;
  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 23;
  localparam logic [DEF_EXP_W-1:0] EXP_MAX = '1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} fpState_t;
  typedef struct packed {
    logic sign;
    logic [DEF_EXP_W-1:0] exponent;
    logic [DEF_MAN_W-1:0] fraction;
  } fpWord_t;
endpackage

// File: rtl/fp_pack.sv
// fp_pack: builds the packed IEEE-754 word, forcing infinity or zero from the flags.
module fp_pack import fp_pkg::*; #(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic             sign,
  input  logic [EXP_W-1:0] exponent,
  input  logic [MAN_W-1:0] fraction,
  input  logic             overflow,
  input  logic             underflow,
  output logic [EXP_W+MAN_W:0] word
);
  always_comb
    word = overflow  ? {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
           underflow ? {sign, {(EXP_W+MAN_W){1'b0}}} :
                       {sign, exponent, fraction};
endmodule

// File: rtl/fp_normalizer.sv
// fp_normalizer: normalizes a raw adder sum (carry/hidden/fraction) into a packed float,
// one left shift per cycle, with overflow saturation and underflow flush-to-zero.
module fp_normalizer import fp_pkg::*; #(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [EXP_W-1:0]     in_exponent,
  input  logic [MAN_W+1:0]     in_mantissa,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_result,
  output logic                 out_overflow,
  output logic                 out_underflow,
  output logic                 busy
);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  fpState_t stateQ, stateD;
  logic signQ, signD, ovfQ, ovfD, unfQ, unfD;
  logic [EXP_W-1:0] expQ, expD, expInc;
  // Only the fraction is stored; the hidden bit is implied by reaching DONE.
  logic [MAN_W-1:0] manQ, manD;
  always_comb begin
    stateD = stateQ;
    signD = signQ;
    expD = expQ;
    manD = manQ;
    ovfD = ovfQ;
    unfD = unfQ;
    expInc = in_exponent + EXP_W'(1);
    case (stateQ)
      IDLE: if (in_valid) begin
        stateD = DONE;
        signD = in_sign;
        expD = in_exponent;
        manD = in_mantissa[MAN_W-1:0];
        ovfD = 1'b0;
        unfD = 1'b0;
        if (in_mantissa == '0) expD = '0;
        else if (in_exponent == EXP_ONES) ovfD = 1'b1;
        else if (in_mantissa[MAN_W+1]) begin
          expD = expInc;
          manD = in_mantissa[MAN_W:1];
          ovfD = expInc == EXP_ONES;
        end else if (!in_mantissa[MAN_W]) begin
          if (in_exponent == '0) unfD = 1'b1;
          else stateD = SHIFT;
        end
      end
      SHIFT: if (expQ == EXP_W'(1)) begin
        unfD = 1'b1;
        stateD = DONE;
      end else begin
        manD = manQ << 1;
        expD = expQ - EXP_W'(1);
        stateD = manQ[MAN_W-1] ? DONE : SHIFT;
      end
      DONE: if (out_ready) begin
        stateD = IDLE;
        ovfD = 1'b0;
        unfD = 1'b0;
      end
      default: stateD = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stateQ <= IDLE;
      signQ <= 1'b0;
      expQ <= '0;
      manQ <= '0;
      ovfQ <= 1'b0;
      unfQ <= 1'b0;
    end else begin
      stateQ <= stateD;
      signQ <= signD;
      expQ <= expD;
      manQ <= manD;
      ovfQ <= ovfD;
      unfQ <= unfD;
    end
  assign in_ready = stateQ == IDLE;
  assign busy = stateQ != IDLE;
  assign out_valid = stateQ == DONE;
  assign out_overflow = ovfQ;
  assign out_underflow = unfQ;
  fp_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) pack (
    .sign(signQ),
    .exponent(expQ),
    .fraction(manQ),
    .overflow(ovfQ),
    .underflow(unfQ),
    .word(out_result)
  );
endmodule
